// File: rtl/main_fsm.sv
// Multicycle ARM controller sequencer: fetch/decode/execute/memory/writeback.
// Moore outputs; RegW/MemW are ungated intent, condition logic gates them downstream.
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC+4
//   DECODE   | read registers, sample Op/Funct
//   MEMADR   | compute load/store address, sample Funct[0]
//   MEMRD    | read data memory at ALUOut
//   MEMWB    | write loaded data to register file
//   MEMWR    | write data memory at ALUOut
//   EXECUTER | ALU op, register operand
//   EXECUTEI | ALU op, immediate operand
//   ALUWB    | write ALU result to register file
//   BRANCH   | compute branch target
module main_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;

   logic [3:0] r_state;
   logic [3:0] w_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Execute/address states must hand off directly to their write state so the
   // registered condition result lines up with the write.
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b01:   w_next = S_MEMADR;
               2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      case (r_state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            NextPC    = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR: ALUSrcB = 2'b01;
         S_MEMRD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         S_EXECUTER: ALUOp = 1'b1;
         S_EXECUTEI: begin
            ALUSrcB = 2'b01;
            ALUOp   = 1'b1;
         end
         S_ALUWB: RegW = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            Branch    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: table of per-cycle inputs and expected Moore outputs,
// plus a hand-written reset-in-MEMRD sequence.
module tb_main_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
   logic [1:0] ALUSrcB, ResultSrc;

   main_fsm dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
      .Branch(Branch), .ALUOp(ALUOp)
   );

   always #5 clk = ~clk;

   // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
   localparam logic [11:0] E_FETCH  = 12'b1_0_1_10_10_1_0_0_0_0;
   localparam logic [11:0] E_DECODE = 12'b0_0_1_10_10_0_0_0_0_0;
   localparam logic [11:0] E_MEMADR = 12'b0_0_0_01_00_0_0_0_0_0;
   localparam logic [11:0] E_MEMRD  = 12'b0_1_0_00_00_0_0_0_0_0;
   localparam logic [11:0] E_MEMWB  = 12'b0_0_0_00_01_0_1_0_0_0;
   localparam logic [11:0] E_MEMWR  = 12'b0_1_0_00_00_0_0_1_0_0;
   localparam logic [11:0] E_EXECR  = 12'b0_0_0_00_00_0_0_0_0_1;
   localparam logic [11:0] E_EXECI  = 12'b0_0_0_01_00_0_0_0_0_1;
   localparam logic [11:0] E_ALUWB  = 12'b0_0_0_00_00_0_1_0_0_0;
   localparam logic [11:0] E_BRANCH = 12'b0_0_0_01_10_0_0_0_1_0;

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  funct;
      logic        rnd;     // drive random Op/Funct: state must ignore them
      logic [11:0] exp;
      string       name;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [11:0] outs();
      return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};
   endfunction

   task automatic check(input string name, input logic [11:0] exp);
      logic [11:0] act;
      act = outs();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: outputs got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      vq.push_back('{2'b00, 6'b001000, 1'b0, E_FETCH,  "add_fetch"});
      vq.push_back('{2'b00, 6'b001000, 1'b0, E_DECODE, "add_decode"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_EXECR,  "add_execr"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_ALUWB,  "add_aluwb"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_FETCH,  "subi_fetch"});
      vq.push_back('{2'b00, 6'b100101, 1'b0, E_DECODE, "subi_decode"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_EXECI,  "subi_execi"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_ALUWB,  "subi_aluwb"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_FETCH,  "ldr_fetch"});
      vq.push_back('{2'b01, 6'b011001, 1'b0, E_DECODE, "ldr_decode"});
      vq.push_back('{2'b01, 6'b011001, 1'b0, E_MEMADR, "ldr_memadr"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_MEMRD,  "ldr_memrd"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_MEMWB,  "ldr_memwb"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_FETCH,  "str_fetch"});
      vq.push_back('{2'b01, 6'b011000, 1'b0, E_DECODE, "str_decode"});
      vq.push_back('{2'b01, 6'b011000, 1'b0, E_MEMADR, "str_memadr"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_MEMWR,  "str_memwr"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_FETCH,  "b_fetch"});
      vq.push_back('{2'b10, 6'b000000, 1'b0, E_DECODE, "b_decode"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_BRANCH, "b_branch"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_FETCH,  "op11_fetch"});
      vq.push_back('{2'b11, 6'b111111, 1'b0, E_DECODE, "op11_decode"});
      vq.push_back('{2'b00, 6'b000000, 1'b1, E_FETCH,  "op11_back_to_fetch"});
      vq.push_back('{2'b01, 6'b000000, 1'b0, E_DECODE, "after_op11_decode"});

      reset = 1'b0;
      Op    = 2'b00;
      Funct = 6'b000000;
      #2 check("reset_state", E_FETCH);
      @(negedge clk);
      reset = 1'b1;

      foreach (vq[i]) begin
         if (vq[i].rnd) begin
            Op    = 2'($urandom_range(0, 3));
            Funct = 6'($urandom_range(0, 63));
         end else begin
            Op    = vq[i].op;
            Funct = vq[i].funct;
         end
         #1 check(vq[i].name, vq[i].exp);
         @(negedge clk);
      end

      // Previous vector was DECODE with Op=01; drive LDR through to MEMRD.
      Op    = 2'b01;
      Funct = 6'b011001;
      #1 check("rst_seq_memadr", E_MEMADR);
      @(negedge clk);
      #1 check("rst_seq_memrd", E_MEMRD);
      #1 reset = 1'b0;
      #1 check("rst_async_fetch", E_FETCH);
      @(negedge clk);
      #1 check("rst_held_1", E_FETCH);
      @(negedge clk);
      #1 check("rst_held_2", E_FETCH);
      @(negedge clk);
      reset = 1'b1;
      Op    = 2'b11;
      #1 check("rst_release_fetch", E_FETCH);
      @(negedge clk);
      #1 check("rst_release_decode", E_DECODE);
      @(negedge clk);
      #1 check("rst_release_op11_fetch", E_FETCH);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
